rv32_instr_encoder: RTL and testbench

- Inverse of the core's control-unit decode path: takes a decoded micro-op descriptor (instruction class, 4-bit ALU op code, register indices, immediate) and packs it into a legal RV32I instruction word.
- Encoded words are written into instruction memory at consecutive word addresses from a programmable base.
- Used by the testbench/boot loader to build programs in IMEM without a hand-assembled hex file.
- Sequencing is handled by a load state machine, a registered output stage with valid/ready backpressure, and an address counter with overflow detection.

---
 rtl/rv32_pkg.sv | 60 ++++++
 rtl/rv32_field_pack.sv | 94 +++++++++
 rtl/rv32_instr_encoder.sv | 144 ++++++++++++++
 tb/tb_rv32_instr_encoder.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I encoding constants used by the encoder and the control unit.
// Opcodes, descriptor classes, ALU op codes and funct3/funct7 values.
package rv32_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        CLS_R      = 4'd0,
        CLS_I_ALU  = 4'd1,
        CLS_LOAD   = 4'd2,
        CLS_STORE  = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_JAL    = 4'd5,
        CLS_JALR   = 4'd6,
        CLS_LUI    = 4'd7,
        CLS_AUIPC  = 4'd8
    } instr_class_e;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef struct packed {
        logic [3:0]  cls;
        logic [3:0]  alu_op;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } uop_t;

endpackage

// File: rtl/rv32_field_pack.sv
// Combinational packer: micro-op descriptor to RV32I word plus legality flag.
module rv32_field_pack
    import rv32_pkg::*;
(
    input  uop_t        uop_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    logic signed [31:0] imm;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic               alu_bad;
    logic               shift;
    logic               fits12;
    logic               b_ok;
    logic               j_ok;

    always_comb begin
        imm     = $signed(uop_i.imm);
        f3      = F3_ADD_SUB;
        f7      = F7_BASE;
        alu_bad = 1'b0;
        case (uop_i.alu_op)
            ALU_ADD:  f3 = F3_ADD_SUB;
            ALU_SUB:  begin f3 = F3_ADD_SUB; f7 = F7_ALT; end
            ALU_AND:  f3 = F3_AND;
            ALU_OR:   f3 = F3_OR;
            ALU_XOR:  f3 = F3_XOR;
            ALU_SLL:  f3 = F3_SLL;
            ALU_SRL:  f3 = F3_SR;
            ALU_SRA:  begin f3 = F3_SR; f7 = F7_ALT; end
            ALU_SLT:  f3 = F3_SLT;
            ALU_SLTU: f3 = F3_SLTU;
            default:  alu_bad = 1'b1;
        endcase
        shift  = uop_i.alu_op inside {ALU_SLL, ALU_SRL, ALU_SRA};
        fits12 = (imm >= -32'sd2048) && (imm <= 32'sd2047);
        b_ok   = (imm >= -32'sd4096) && (imm <= 32'sd4095) && !imm[0];
        j_ok   = (imm >= -32'sd1048576) && (imm <= 32'sd1048575) && !imm[0];
    end

    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        case (uop_i.cls)
            CLS_R: begin
                word_o    = {f7, uop_i.rs2, uop_i.rs1, f3, uop_i.rd, OPC_OP};
                illegal_o = alu_bad;
            end
            CLS_I_ALU: begin
                if (shift) begin
                    word_o    = {f7, imm[4:0], uop_i.rs1, f3, uop_i.rd, OPC_OP_IMM};
                    illegal_o = alu_bad || (uop_i.imm > 32'd31);
                end else begin
                    word_o    = {imm[11:0], uop_i.rs1, f3, uop_i.rd, OPC_OP_IMM};
                    illegal_o = alu_bad || (uop_i.alu_op == ALU_SUB) || !fits12;
                end
            end
            CLS_LOAD: begin
                word_o    = {imm[11:0], uop_i.rs1, uop_i.funct3, uop_i.rd, OPC_LOAD};
                illegal_o = !fits12 || (uop_i.funct3 inside {3'b011, 3'b110, 3'b111});
            end
            CLS_STORE: begin
                word_o    = {imm[11:5], uop_i.rs2, uop_i.rs1, uop_i.funct3,
                             imm[4:0], OPC_STORE};
                illegal_o = !fits12 || (uop_i.funct3 > 3'b010);
            end
            CLS_BRANCH: begin
                word_o    = {imm[12], imm[10:5], uop_i.rs2, uop_i.rs1, uop_i.funct3,
                             imm[4:1], imm[11], OPC_BRANCH};
                illegal_o = !b_ok || (uop_i.funct3 inside {3'b010, 3'b011});
            end
            CLS_JAL: begin
                word_o    = {imm[20], imm[10:1], imm[11], imm[19:12], uop_i.rd, OPC_JAL};
                illegal_o = !j_ok;
            end
            CLS_JALR: begin
                word_o    = {imm[11:0], uop_i.rs1, 3'b000, uop_i.rd, OPC_JALR};
                illegal_o = !fits12;
            end
            CLS_LUI: begin
                word_o    = {imm[31:12], uop_i.rd, OPC_LUI};
                illegal_o = (imm[11:0] != 12'd0);
            end
            CLS_AUIPC: begin
                word_o    = {imm[31:12], uop_i.rd, OPC_AUIPC};
                illegal_o = (imm[11:0] != 12'd0);
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv32_instr_encoder.sv
// Load sequencer: packs descriptors into RV32I words and streams them to IMEM
// at consecutive word addresses, with backpressure and overflow detection.
module rv32_instr_encoder
    import rv32_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        in_class,
    input  logic [3:0]        in_alu_op,
    input  logic [2:0]        in_funct3,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_data,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_overflow
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              vld_q, vld_d;
    logic [31:0]       data_q, data_d;
    logic              last_q, last_d;
    logic              ill_q, ill_d;
    logic              ovf_q, ovf_d;

    uop_t        uop;
    logic [31:0] word;
    logic        illegal;
    logic        wr_hs;
    logic        at_end;
    logic        blocked;
    logic        ovf_hit;
    logic        accept;

    assign uop = '{cls: in_class, alu_op: in_alu_op, funct3: in_funct3,
                   rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};

    rv32_field_pack u_pack (
        .uop_i     (uop),
        .word_o    (word),
        .illegal_o (illegal)
    );

    // A non-last word parked at the final address leaves no room for more input.
    always_comb begin
        wr_hs    = vld_q && out_ready;
        at_end   = (addr_q == LAST_ADDR);
        blocked  = vld_q && at_end && !last_q;
        ovf_hit  = (state_q == S_RUN) && wr_hs && at_end && !last_q;
        in_ready = (state_q == S_RUN) && (!vld_q || out_ready) && !blocked;
        accept   = in_valid && in_ready;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        vld_d   = vld_q;
        data_d  = data_q;
        last_d  = last_q;
        ill_d   = ill_q;
        ovf_d   = ovf_q;
        if (wr_hs) begin
            vld_d = 1'b0;
            if (!at_end) addr_d = addr_q + 1'b1;
        end
        if (accept) begin
            if (illegal) begin
                ill_d = 1'b1;
            end else begin
                vld_d  = 1'b1;
                data_d = word;
                last_d = in_last;
            end
        end
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    addr_d  = base_addr;
                    ill_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (ovf_hit) begin
                    ovf_d   = 1'b1;
                    state_d = S_FLUSH;
                end else if (accept && in_last) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: if (!vld_q || wr_hs) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            ill_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            last_q  <= last_d;
            ill_q   <= ill_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid    = vld_q;
    assign out_addr     = addr_q;
    assign out_data     = data_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign err_illegal  = ill_q;
    assign err_overflow = ovf_q;

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// Self-checking bench for rv32_instr_encoder: directed scenarios plus
// randomized sessions scored against a field-level encoding model.
module tb_rv32_instr_encoder;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [3:0]        in_class;
    logic [3:0]        in_alu_op;
    logic [2:0]        in_funct3;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [31:0]       out_data;
    logic              busy;
    logic              done;
    logic              err_illegal;
    logic              err_overflow;

    int errors = 0;
    int checks = 0;
    bit rand_rdy = 1'b0;
    logic [41:0] wr_q[$];

    typedef struct {
        logic [3:0]  cls;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        last;
    } d_t;

    rv32_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_class(in_class), .in_alu_op(in_alu_op), .in_funct3(in_funct3),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .busy(busy), .done(done),
        .err_illegal(err_illegal), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst && out_valid && out_ready)
            wr_q.push_back({out_addr, out_data});

    function automatic int bits(input int v, input int hi, input int lo);
        return (v >>> lo) & ((1 << (hi - lo + 1)) - 1);
    endfunction

    function automatic logic [31:0] at(input int v, input int lsb);
        return 32'(v) << lsb;
    endfunction

    function automatic void model(input d_t d, output logic [31:0] w, output bit ill);
        int f3t[10];
        int f7t[10];
        int s, f3, f7;
        bit shift, r12;
        f3t = '{0, 0, 7, 6, 4, 1, 5, 5, 2, 3};
        f7t = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
        s = int'(d.imm);
        f3 = (d.alu < 10) ? f3t[d.alu] : 0;
        f7 = (d.alu < 10) ? f7t[d.alu] : 0;
        shift = (d.alu == 5) || (d.alu == 6) || (d.alu == 7);
        r12 = (s >= -2048) && (s <= 2047);
        w = 0;
        ill = 0;
        case (d.cls)
            0: begin
                ill = d.alu > 9;
                w = at(f7, 25) | at(d.rs2, 20) | at(d.rs1, 15) | at(f3, 12) | at(d.rd, 7) | 32'h33;
            end
            1: begin
                if (shift) begin
                    ill = d.imm > 32'd31;
                    w = at(f7 * 32 + bits(s, 4, 0), 20);
                end else begin
                    ill = (d.alu > 9) || (d.alu == 1) || !r12;
                    w = at(bits(s, 11, 0), 20);
                end
                w = w | at(d.rs1, 15) | at(f3, 12) | at(d.rd, 7) | 32'h13;
            end
            2: begin
                ill = !r12 || d.f3 == 3 || d.f3 == 6 || d.f3 == 7;
                w = at(bits(s, 11, 0), 20) | at(d.rs1, 15) | at(d.f3, 12) | at(d.rd, 7) | 32'h03;
            end
            3: begin
                ill = !r12 || d.f3 > 2;
                w = at(bits(s, 11, 5), 25) | at(d.rs2, 20) | at(d.rs1, 15) | at(d.f3, 12)
                  | at(bits(s, 4, 0), 7) | 32'h23;
            end
            4: begin
                ill = s < -4096 || s > 4095 || (s & 1) != 0 || d.f3 == 2 || d.f3 == 3;
                w = at(bits(s, 12, 12), 31) | at(bits(s, 10, 5), 25) | at(d.rs2, 20)
                  | at(d.rs1, 15) | at(d.f3, 12) | at(bits(s, 4, 1), 8)
                  | at(bits(s, 11, 11), 7) | 32'h63;
            end
            5: begin
                ill = s < -1048576 || s > 1048575 || (s & 1) != 0;
                w = at(bits(s, 20, 20), 31) | at(bits(s, 10, 1), 21) | at(bits(s, 11, 11), 20)
                  | at(bits(s, 19, 12), 12) | at(d.rd, 7) | 32'h6F;
            end
            6: begin
                ill = !r12;
                w = at(bits(s, 11, 0), 20) | at(d.rs1, 15) | at(d.rd, 7) | 32'h67;
            end
            7, 8: begin
                ill = (s % 4096) != 0;
                w = (d.imm & 32'hFFFFF000) | at(d.rd, 7) | ((d.cls == 7) ? 32'h37 : 32'h17);
            end
            default: ill = 1;
        endcase
    endfunction

    function automatic d_t mk(input int cls, input int alu, input int rd, input int rs1,
                              input int rs2, input int imm, input bit last);
        d_t d;
        d.cls = 4'(cls); d.alu = 4'(alu); d.f3 = 3'd0;
        d.rd = 5'(rd); d.rs1 = 5'(rs1); d.rs2 = 5'(rs2);
        d.imm = 32'(imm); d.last = last;
        return d;
    endfunction

    task automatic tick();
        @(negedge clk);
        if (rand_rdy) out_ready = 1'($urandom);
        #1;
    endtask

    task automatic start_session(input logic [ADDR_W-1:0] b);
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    task automatic send(input d_t d);
        int n = 0;
        in_class = d.cls; in_alu_op = d.alu; in_funct3 = d.f3;
        in_rd = d.rd; in_rs1 = d.rs1; in_rs2 = d.rs2;
        in_imm = d.imm; in_last = d.last; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_accept: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_pulse: done not seen within 100 cycles, required 1");
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle: done=%0b busy=%0b, required 0 0", done, busy);
        end
    endtask

    task automatic check_writes(input string nm, input int wb, input logic [41:0] exp[$]);
        checks++;
        if (wr_q.size() - wb != exp.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d writes, required %0d", nm, wr_q.size() - wb, exp.size());
        end
        foreach (exp[j]) begin
            checks++;
            if (wr_q.size() <= wb + j || wr_q[wb + j] !== exp[j]) begin
                errors++;
                $display("FAIL %s_write%0d: got %h, required %h", nm, j,
                         (wr_q.size() > wb + j) ? wr_q[wb + j] : 42'h0, exp[j]);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({in_ready, out_valid, out_addr, out_data, busy, done, err_illegal, err_overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%0b addr=%h data=%h busy=%0b, required all 0",
                     out_valid, out_addr, out_data, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if ({in_ready, out_valid, busy, done} !== 4'b0) begin
            errors++;
            $display("FAIL reset_idle: ready=%0b valid=%0b busy=%0b done=%0b, required 0",
                     in_ready, out_valid, busy, done);
        end
    endtask

    task automatic test_single();
        int wb;
        bit seen;
        logic [41:0] exp[$];
        out_ready = 1'b1;
        start_session(10'h010);
        wb = wr_q.size();
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_run: busy=%0b in_ready=%0b, required 1 1", busy, in_ready);
        end
        send(mk(0, 0, 3, 1, 2, 0, 1));
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h002081B3 || out_addr !== 10'h010) begin
            errors++;
            $display("FAIL single_add: valid=%0b data=%h addr=%h, required 1 002081b3 010",
                     out_valid, out_data, out_addr);
        end
        wait_done(seen);
        exp.push_back({10'h010, 32'h002081B3});
        check_writes("single", wb, exp);
    endtask

    task automatic test_back_to_back();
        int wb;
        bit seen;
        logic [41:0] exp[$];
        out_ready = 1'b1;
        start_session(10'h010);
        wb = wr_q.size();
        send(mk(0, 1, 3, 1, 2, 0, 0));
        checks++;
        if (out_data !== 32'h402081B3 || out_addr !== 10'h010) begin
            errors++;
            $display("FAIL b2b_sub: data=%h addr=%h, required 402081b3 010", out_data, out_addr);
        end
        send(mk(1, 0, 1, 0, 0, -1, 1));
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hFFF00093 || out_addr !== 10'h011) begin
            errors++;
            $display("FAIL b2b_addi: valid=%0b data=%h addr=%h, required 1 fff00093 011",
                     out_valid, out_data, out_addr);
        end
        wait_done(seen);
        exp.push_back({10'h010, 32'h402081B3});
        exp.push_back({10'h011, 32'hFFF00093});
        check_writes("b2b", wb, exp);
    endtask

    task automatic test_backpressure();
        int wb;
        bit seen;
        logic [41:0] exp[$];
        out_ready = 1'b0;
        start_session(10'h040);
        wb = wr_q.size();
        send(mk(1, 7, 5, 6, 0, 3, 0));
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h40335293 || out_addr !== 10'h040
                || in_ready !== 1'b0 || wr_q.size() != wb) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%0b data=%h in_ready=%0b writes=%0d, required 1 40335293 0 0",
                         i, out_valid, out_data, in_ready, wr_q.size() - wb);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (wr_q.size() - wb != 1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: writes=%0d valid=%0b, required 1 0", wr_q.size() - wb, out_valid);
        end
        send(mk(0, 0, 3, 1, 2, 0, 1));
        wait_done(seen);
        exp.push_back({10'h040, 32'h40335293});
        exp.push_back({10'h041, 32'h002081B3});
        check_writes("bp", wb, exp);
    endtask

    task automatic test_illegal();
        int wb;
        bit seen;
        logic [41:0] exp[$];
        out_ready = 1'b1;
        start_session(10'h020);
        wb = wr_q.size();
        send(mk(1, 1, 3, 1, 0, 5, 0));
        checks++;
        if (err_illegal !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_sub: err_illegal=%0b valid=%0b, required 1 0", err_illegal, out_valid);
        end
        send(mk(7, 0, 1, 0, 0, 32'h12345000, 1));
        checks++;
        if (out_data !== 32'h123450B7 || out_addr !== 10'h020) begin
            errors++;
            $display("FAIL illegal_lui: data=%h addr=%h, required 123450b7 020", out_data, out_addr);
        end
        wait_done(seen);
        exp.push_back({10'h020, 32'h123450B7});
        check_writes("illegal", wb, exp);
        checks++;
        if (err_illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_sticky: err_illegal=%0b, required 1", err_illegal);
        end
    endtask

    task automatic test_overflow();
        int wb;
        bit seen;
        logic [41:0] exp[$];
        out_ready = 1'b1;
        start_session(10'(DEPTH - 1));
        wb = wr_q.size();
        checks++;
        if (err_illegal !== 1'b0) begin
            errors++;
            $display("FAIL start_clears_illegal: err_illegal=%0b, required 0", err_illegal);
        end
        send(mk(0, 0, 3, 1, 2, 0, 0));
        in_class = 4'd5; in_rd = 5'd1; in_imm = 32'd8; in_last = 1'b0; in_valid = 1'b1;
        wait_done(seen);
        in_valid = 1'b0;
        exp.push_back({10'(DEPTH - 1), 32'h002081B3});
        check_writes("ovf", wb, exp);
        checks++;
        if (err_overflow !== 1'b1 || out_addr !== 10'(DEPTH - 1)) begin
            errors++;
            $display("FAIL ovf_flag: err_overflow=%0b addr=%h, required 1 3ff", err_overflow, out_addr);
        end
    endtask

    task automatic test_async_reset();
        int wb;
        out_ready = 1'b0;
        start_session(10'h100);
        checks++;
        if (err_overflow !== 1'b0) begin
            errors++;
            $display("FAIL start_clears_overflow: err_overflow=%0b, required 0", err_overflow);
        end
        wb = wr_q.size();
        send(mk(0, 0, 3, 1, 2, 0, 0));
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, out_addr, out_data, busy, done, err_illegal, err_overflow} !== '0) begin
            errors++;
            $display("FAIL async_reset: valid=%0b addr=%h data=%h busy=%0b, required all 0",
                     out_valid, out_addr, out_data, busy);
        end
        out_ready = 1'b1;
        #3;
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (wr_q.size() != wb || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_nowrite: writes=%0d busy=%0b, required 0 0", wr_q.size() - wb, busy);
        end
    endtask

    task automatic test_random();
        int pick[18];
        pick = '{-2049, -2048, 2047, 2048, -4096, -4097, 4094, 4095, 4096,
                 31, 32, -1, 0, 8, 1048574, 1048576, -1048576, -1048578};
        rand_rdy = 1'b1;
        for (int s = 0; s < 5; s++) begin
            int n, wb, k;
            bit anyill, seen, ill;
            logic [ADDR_W-1:0] base;
            logic [31:0] w;
            logic [41:0] exp[$];
            d_t d;
            n = $urandom_range(8, 16);
            base = 10'($urandom_range(0, 900));
            k = 0;
            anyill = 0;
            start_session(base);
            wb = wr_q.size();
            for (int i = 0; i < n; i++) begin
                d.cls = 4'($urandom_range(0, 9));
                d.alu = 4'($urandom_range(0, 11));
                d.f3 = 3'($urandom);
                d.rd = 5'($urandom); d.rs1 = 5'($urandom); d.rs2 = 5'($urandom);
                case ($urandom_range(0, 3))
                    0: d.imm = 32'(pick[$urandom_range(0, 17)]);
                    1: d.imm = 32'($urandom_range(0, 4200)) - 32'd2100;
                    2: d.imm = $urandom & 32'hFFFFF000;
                    default: d.imm = 32'($urandom_range(0, 31));
                endcase
                d.last = (i == n - 1);
                model(d, w, ill);
                if (ill) anyill = 1;
                else begin
                    exp.push_back({10'(base + 10'(k)), w});
                    k++;
                end
                send(d);
            end
            wait_done(seen);
            check_writes("rand", wb, exp);
            checks++;
            if (err_illegal !== anyill || err_overflow !== 1'b0) begin
                errors++;
                $display("FAIL rand_flags%0d: err_illegal=%0b err_overflow=%0b, required %0b 0",
                         s, err_illegal, err_overflow, anyill);
            end
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0;
        in_valid = 1'b0; in_last = 1'b0; in_class = '0; in_alu_op = '0;
        in_funct3 = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_overflow();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
